// File: rtl/mul_err_profiler.sv
// Exhaustive error profiler for approximate multipliers: sweeps every operand
// pair, aligns each product with its operands and accumulates error statistics.
module mul_err_profiler #(
    parameter int WIDTH       = 8,
    parameter int MUL_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     mul_in1,
    output logic [WIDTH-1:0]     mul_in2,
    input  logic [2*WIDTH-2:0]   mul_out,
    input  logic                 mul_overflow,
    output logic [2*WIDTH:0]     err_count,
    output logic [4*WIDTH-1:0]   err_sum,
    output logic [2*WIDTH-1:0]   err_max,
    output logic [WIDTH-1:0]     worst_in1,
    output logic [WIDTH-1:0]     worst_in2
);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [PW-1:0]      r_idx;
    logic [2:0]         r_dcnt;
    logic               r_busy, r_done;

    // Stage 0 of the delay line doubles as the registered operand outputs.
    logic               r_vld [MUL_LATENCY];
    logic [WIDTH-1:0]   r_d1  [MUL_LATENCY];
    logic [WIDTH-1:0]   r_d2  [MUL_LATENCY];

    logic [PW:0]        r_cnt;
    logic [4*WIDTH-1:0] r_sum;
    logic [PW-1:0]      r_max;
    logic [WIDTH-1:0]   r_w1, r_w2;

    logic               w_accept, w_last, w_drain_end, w_vs;
    logic [WIDTH-1:0]   w_a1, w_a2;
    logic [PW-1:0]      w_exact, w_approx, w_err;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_last      = &r_idx;
    assign w_drain_end = (r_dcnt == 3'(MUL_LATENCY - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)       w_next = S_RUN;
            S_RUN:   if (w_last)      w_next = S_DRAIN;
            S_DRAIN: if (w_drain_end) w_next = S_DONE;
            S_DONE:                   w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_dcnt <= '0;
        end else begin
            if (w_accept)               r_idx <= '0;
            else if (r_state == S_RUN)  r_idx <= r_idx + {{(PW-1){1'b0}}, 1'b1};
            if (r_state == S_DRAIN)     r_dcnt <= r_dcnt + 3'd1;
            else                        r_dcnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            for (int j = 0; j < MUL_LATENCY; j++) begin
                r_vld[j] <= 1'b0;
                r_d1[j]  <= '0;
                r_d2[j]  <= '0;
            end
        end else begin
            r_busy   <= (r_state == S_RUN) || (r_state == S_DRAIN);
            r_done   <= (r_state == S_DONE);
            r_vld[0] <= (r_state == S_RUN);
            r_d1[0]  <= (r_state == S_RUN) ? r_idx[WIDTH-1:0]  : '0;
            r_d2[0]  <= (r_state == S_RUN) ? r_idx[PW-1:WIDTH] : '0;
            for (int j = 1; j < MUL_LATENCY; j++) begin
                r_vld[j] <= r_vld[j-1];
                r_d1[j]  <= r_d1[j-1];
                r_d2[j]  <= r_d2[j-1];
            end
        end
    end

    // The product sampled now belongs to the pair issued MUL_LATENCY-1 stages ago.
    assign w_vs     = r_vld[MUL_LATENCY-1];
    assign w_a1     = r_d1[MUL_LATENCY-1];
    assign w_a2     = r_d2[MUL_LATENCY-1];
    assign w_exact  = {{WIDTH{1'b0}}, w_a1} * {{WIDTH{1'b0}}, w_a2};
    assign w_approx = {mul_overflow, mul_out};
    assign w_err    = (w_approx > w_exact) ? (w_approx - w_exact) : (w_exact - w_approx);

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_cnt <= '0;
            r_sum <= '0;
            r_max <= '0;
            r_w1  <= '0;
            r_w2  <= '0;
        end else if (w_vs) begin
            if (w_err != '0) r_cnt <= r_cnt + {{PW{1'b0}}, 1'b1};
            r_sum <= r_sum + {{(4*WIDTH-PW){1'b0}}, w_err};
            if (w_err > r_max) begin
                r_max <= w_err;
                r_w1  <= w_a1;
                r_w2  <= w_a2;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mul_in1   = r_d1[0];
    assign mul_in2   = r_d2[0];
    assign err_count = r_cnt;
    assign err_sum   = r_sum;
    assign err_max   = r_max;
    assign worst_in1 = r_w1;
    assign worst_in2 = r_w2;
endmodule

// File: tb/tb_mul_err_profiler.sv
// Bench for mul_err_profiler: exact 8-bit sweep plus table-driven 4-bit stubs
// (combinational and 3-cycle) compared against a pair-by-pair statistics model.
module tb_mul_err_profiler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: WIDTH=8, MUL_LATENCY=1, exact multiplier
    logic        st_a, busy_a, done_a, ovf_a;
    logic [7:0]  in1_a, in2_a, w1_a, w2_a;
    logic [14:0] out_a;
    logic [16:0] cnt_a;
    logic [31:0] sum_a;
    logic [15:0] max_a, prod_a;
    assign prod_a = {8'd0, in1_a} * {8'd0, in2_a};
    assign out_a  = prod_a[14:0];
    assign ovf_a  = prod_a[15];

    // Shared product table for the 4-bit stubs, indexed by {in2,in1}
    logic [7:0] tab [256];

    // Instance B: WIDTH=4, MUL_LATENCY=3 (two register stages in the stub)
    logic        st_b, busy_b, done_b, ovf_b;
    logic [3:0]  in1_b, in2_b, w1_b, w2_b;
    logic [6:0]  out_b;
    logic [8:0]  cnt_b;
    logic [15:0] sum_b;
    logic [7:0]  max_b, s1_b, s2_b;
    always @(posedge clk) begin
        s1_b <= tab[{in2_b, in1_b}];
        s2_b <= s1_b;
    end
    assign out_b = s2_b[6:0];
    assign ovf_b = s2_b[7];

    // Instance C: WIDTH=4, MUL_LATENCY=1 (combinational stub)
    logic        st_c, busy_c, done_c, ovf_c;
    logic [3:0]  in1_c, in2_c, w1_c, w2_c;
    logic [6:0]  out_c;
    logic [8:0]  cnt_c;
    logic [15:0] sum_c;
    logic [7:0]  max_c, prod_c;
    assign prod_c = tab[{in2_c, in1_c}];
    assign out_c  = prod_c[6:0];
    assign ovf_c  = prod_c[7];

    mul_err_profiler #(.WIDTH(8), .MUL_LATENCY(1)) u_a (
        .clk(clk), .rst(rst), .start(st_a), .busy(busy_a), .done(done_a),
        .mul_in1(in1_a), .mul_in2(in2_a), .mul_out(out_a), .mul_overflow(ovf_a),
        .err_count(cnt_a), .err_sum(sum_a), .err_max(max_a),
        .worst_in1(w1_a), .worst_in2(w2_a));

    mul_err_profiler #(.WIDTH(4), .MUL_LATENCY(3)) u_b (
        .clk(clk), .rst(rst), .start(st_b), .busy(busy_b), .done(done_b),
        .mul_in1(in1_b), .mul_in2(in2_b), .mul_out(out_b), .mul_overflow(ovf_b),
        .err_count(cnt_b), .err_sum(sum_b), .err_max(max_b),
        .worst_in1(w1_b), .worst_in2(w2_b));

    mul_err_profiler #(.WIDTH(4), .MUL_LATENCY(1)) u_c (
        .clk(clk), .rst(rst), .start(st_c), .busy(busy_c), .done(done_c),
        .mul_in1(in1_c), .mul_in2(in2_c), .mul_out(out_c), .mul_overflow(ovf_c),
        .err_count(cnt_c), .err_sum(sum_c), .err_max(max_c),
        .worst_in1(w1_c), .worst_in2(w2_c));

    // Selected 4-bit instance view (0 = B, 1 = C)
    int          sel = 0;
    logic        t_busy, t_done;
    logic [3:0]  t_in1, t_in2, t_w1, t_w2;
    logic [8:0]  t_cnt;
    logic [15:0] t_sum;
    logic [7:0]  t_max;
    assign t_busy = (sel == 0) ? busy_b : busy_c;
    assign t_done = (sel == 0) ? done_b : done_c;
    assign t_in1  = (sel == 0) ? in1_b  : in1_c;
    assign t_in2  = (sel == 0) ? in2_b  : in2_c;
    assign t_cnt  = (sel == 0) ? cnt_b  : cnt_c;
    assign t_sum  = (sel == 0) ? sum_b  : sum_c;
    assign t_max  = (sel == 0) ? max_b  : max_c;
    assign t_w1   = (sel == 0) ? w1_b   : w1_c;
    assign t_w2   = (sel == 0) ? w2_b   : w2_c;

    int nchk = 0;
    int nerr = 0;
    int e_cnt, e_sum, e_max, e_w1, e_w2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference statistics: walk the pairs in issue order with plain arithmetic.
    task automatic model();
        int a, b, ex, ap, e;
        e_cnt = 0; e_sum = 0; e_max = 0; e_w1 = 0; e_w2 = 0;
        for (int p = 0; p < 256; p++) begin
            a  = p % 16;
            b  = p / 16;
            ex = a * b;
            ap = int'(tab[p]);
            e  = (ap > ex) ? ap - ex : ex - ap;
            if (e != 0) e_cnt++;
            e_sum += e;
            if (e > e_max) begin e_max = e; e_w1 = a; e_w2 = b; end
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 0) st_b = v;
        else            st_c = v;
    endtask

    task automatic sweep4(input int which, input int lat, input int restart_at, input string tag);
        int cyc, bcnt;
        bit fin;
        sel = which;
        model();
        @(negedge clk); set_start(which, 1'b1);
        @(negedge clk); set_start(which, 1'b0);
        cyc = 0; bcnt = 0; fin = 0;
        while (!fin && cyc < 2000) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (cyc == 1) begin
                chk({tag, "_busy1"}, 64'(t_busy), 64'd1);
                chk({tag, "_pair0"}, 64'({t_in2, t_in1}), 64'd0);
            end
            if (cyc == 2) chk({tag, "_pair1"}, 64'({t_in2, t_in1}), 64'd1);
            if (t_busy) bcnt++;
            set_start(which, cyc == restart_at);
            if (t_done) fin = 1;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(257 + lat));
        chk({tag, "_busycyc"}, 64'(bcnt), 64'(256 + lat));
        chk({tag, "_busy_at_done"}, 64'(t_busy), 64'd0);
        chk({tag, "_count"}, 64'(t_cnt), 64'(e_cnt));
        chk({tag, "_sum"},   64'(t_sum), 64'(e_sum));
        chk({tag, "_max"},   64'(t_max), 64'(e_max));
        chk({tag, "_worst"}, 64'({t_w2, t_w1}), 64'(e_w2 * 16 + e_w1));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(t_done), 64'd0);
        chk({tag, "_hold_max"},   64'(t_max), 64'(e_max));
    endtask

    initial begin
        int cyc, bcnt, k, dpulse;
        bit fin;
        st_a = 0; st_b = 0; st_c = 0;
        for (int p = 0; p < 256; p++) tab[p] = 8'((p % 16) * (p / 16));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ctl", {busy_a, done_a, in1_a, in2_a, w1_a, w2_a}, 64'd0);
        chk("rst_a_stat", {cnt_a, sum_a, max_a}, 64'd0);
        chk("rst_b", {busy_b, done_b, in1_b, in2_b, cnt_b, sum_b, max_b, w1_b, w2_b}, 64'd0);
        chk("rst_c", {busy_c, done_c, in1_c, in2_c, cnt_c, sum_c, max_c, w1_c, w2_c}, 64'd0);
        rst = 1'b0;

        // Exact 8-bit sweep with a randomly chosen pair-order probe
        k = $urandom_range(65535, 0);
        @(negedge clk); st_a = 1'b1;
        @(negedge clk); st_a = 1'b0;
        cyc = 0; bcnt = 0; fin = 0;
        while (!fin && cyc < 70000) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (cyc == k + 1) chk("a_pair_order", 64'({in2_a, in1_a}), 64'(k));
            if (busy_a) bcnt++;
            if (done_a) fin = 1;
        end
        chk("a_latency", 64'(cyc), 64'd65538);
        chk("a_busycyc", 64'(bcnt), 64'd65537);
        chk("a_stats", {cnt_a, sum_a, max_a}, 64'd0);
        chk("a_worst", {w1_a, w2_a}, 64'd0);

        // Product bit 0 flipped everywhere (tie keeps pair 0)
        for (int p = 0; p < 256; p++) tab[p] = 8'((p % 16) * (p / 16)) ^ 8'd1;
        sweep4(1, 1, -1, "xor_c");
        sweep4(0, 3, -1, "xor_b");

        // Only 15*15 off by one, 3-cycle multiplier
        for (int p = 0; p < 256; p++) tab[p] = 8'((p % 16) * (p / 16));
        tab[255] = tab[255] + 8'd1;
        sweep4(0, 3, -1, "one_b");

        // Overflow bit forced for 1*1
        for (int p = 0; p < 256; p++) tab[p] = 8'((p % 16) * (p / 16));
        tab[17] = 8'h81;
        sweep4(1, 1, -1, "ovf_c");

        // Random error table; second start ignored mid-run; rerun reproduces
        for (int p = 0; p < 256; p++)
            tab[p] = ($urandom_range(1, 0) == 1) ? 8'((p % 16) * (p / 16)) : 8'($urandom_range(255, 0));
        sweep4(1, 1, 100, "rnd_c_restart");
        sweep4(1, 1, -1, "rnd_c_again");
        sweep4(0, 3, 100, "rnd_b");

        // Reset mid-sweep: everything clears, no done pulse, then a full sweep
        sel = 1;
        @(negedge clk); st_c = 1'b1;
        @(negedge clk); st_c = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_ctl", {t_busy, t_done, t_in1, t_in2}, 64'd0);
        chk("mrst_stat", {t_cnt, t_sum, t_max, t_w1, t_w2}, 64'd0);
        dpulse = 0;
        repeat (300) begin
            @(negedge clk);
            if (t_done || t_busy) dpulse++;
        end
        chk("mrst_no_done", 64'(dpulse), 64'd0);
        sweep4(1, 1, -1, "post_rst_c");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
